// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM encoding, default
// timing constants and a small elaboration-time helper.
package stopwatch_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } state_t;

    localparam int DEF_DIV_RUN   = 100_000_000;
    localparam int DEF_DIV_ADJ   = 50_000_000;
    localparam int DEF_DB_CYCLES = 1_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Two-flop synchronizer followed by a counting debouncer; flip is high in the
// cycle whose closing edge changes the debounced level.
module debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic flip
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          db_reg;
    logic [CW-1:0] cnt_reg;

    // The counter only runs while the synchronized level disagrees with the output.
    assign flip = (sync2_reg != db_reg) && (cnt_reg == CNT_LAST);
    assign db   = db_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            db_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg == db_reg) begin
                cnt_reg <= '0;
            end else if (flip) begin
                db_reg  <= sync2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons, RUN/PAUSED FSM, mode-dependent
// prescaler and registered enable / clear pulses for the counter chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV_RUN   = DEF_DIV_RUN,
    parameter int DIV_ADJ   = DEF_DIV_ADJ,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pause,
    input  logic btn_reset,
    input  logic sw_adj,
    output logic en,
    output logic cnt_clr,
    output logic adj,
    output logic paused
);
    localparam int PW_RAW = $clog2(max_int(DIV_RUN, DIV_ADJ));
    localparam int PW     = (PW_RAW > 0) ? PW_RAW : 1;
    localparam logic [PW-1:0] RUN_LAST = PW'(DIV_RUN - 1);
    localparam logic [PW-1:0] ADJ_LAST = PW'(DIV_ADJ - 1);

    localparam int IDX_PAUSE = 0;
    localparam int IDX_RESET = 1;
    localparam int IDX_ADJ   = 2;

    logic [2:0] raw_vec;
    logic [2:0] db_vec;
    logic [2:0] flip_vec;

    assign raw_vec = {sw_adj, btn_reset, btn_pause};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_debounce
            debounce #(
                .DB_CYCLES(DB_CYCLES)
            ) u_debounce (
                .clk (clk),
                .rst (rst),
                .raw (raw_vec[gi]),
                .db  (db_vec[gi]),
                .flip(flip_vec[gi])
            );
        end
    endgenerate

    state_t        state_reg;
    logic          paused_reg;
    logic          en_reg;
    logic          cnt_clr_reg;
    logic          pause_pulse_reg;
    logic          reset_pulse_reg;
    logic [PW-1:0] presc_reg;

    logic          adj_level;
    logic          adj_flip;
    logic [PW-1:0] presc_last;
    logic          tick;

    assign adj_level  = db_vec[IDX_ADJ];
    assign adj_flip   = flip_vec[IDX_ADJ];
    assign presc_last = adj_level ? ADJ_LAST : RUN_LAST;
    // A mode change restarts the prescaler, so the terminal count of the old mode is dropped.
    assign tick       = (presc_reg == presc_last) && !adj_flip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= PAUSED;
            paused_reg      <= 1'b1;
            en_reg          <= 1'b0;
            cnt_clr_reg     <= 1'b0;
            pause_pulse_reg <= 1'b0;
            reset_pulse_reg <= 1'b0;
            presc_reg       <= '0;
        end else begin
            // Rising edges of the debounced buttons, one cycle after the level flips.
            pause_pulse_reg <= flip_vec[IDX_PAUSE] && !db_vec[IDX_PAUSE];
            reset_pulse_reg <= flip_vec[IDX_RESET] && !db_vec[IDX_RESET];

            cnt_clr_reg <= reset_pulse_reg;
            en_reg      <= tick && (state_reg == RUN || adj_level) && !reset_pulse_reg;

            if (reset_pulse_reg || adj_flip || tick) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end

            // A clear wins over a coincident pause press.
            if (pause_pulse_reg && !reset_pulse_reg) begin
                state_reg  <= (state_reg == RUN) ? PAUSED : RUN;
                paused_reg <= (state_reg == RUN);
            end
        end
    end

    assign en      = en_reg;
    assign cnt_clr = cnt_clr_reg;
    assign adj     = adj_level;
    assign paused  = paused_reg;

endmodule
